async_fifo_fwft: RTL
====================

Name: async_fifo_fwft

Overview:
- Parametrised dual-clock FIFO between a write domain (clk_1) and a read domain (clk_2).
- Pointers cross domains as Gray codes through flop synchronisers.
- Read side is first-word-fall-through with a valid/ready handshake.
- Adds occupancy counts, almost-full/almost-empty flags, and a sticky overflow flag.

Parameters:
- DATA_W, 16, width of each stored word.
- ADDR_W, 3, log2 of depth; DEPTH = 2^ADDR_W, so 8 entries by default.
- SYNC_STAGES, 2, flops per clock-domain-crossing synchroniser; legal range 2..4.
- AF_LEVEL, 6, wr_almost_full asserts when wr_count >= AF_LEVEL.
- AE_LEVEL, 1, rd_almost_empty asserts when rd_count <= AE_LEVEL.

Ports:
- clk_1, in, 1, write-domain clock.
- rst, in, 1, reset: synchronous, active-high, sampled on clk_1.
- clk_2, in, 1, read-domain clock.
- wr_en, in, 1, write request.
- wr_data, in, DATA_W, write data.
- wr_full, out, 1, write side full; writes are rejected while high.
- wr_almost_full, out, 1, wr_count >= AF_LEVEL.
- wr_count, out, ADDR_W+1, occupancy seen from clk_1.
- wr_overflow, out, 1, sticky: a write was attempted while full.
- rd_ready, in, 1, consumer accepts rd_data.
- rd_valid, out, 1, rd_data holds a valid word.
- rd_data, out, DATA_W, head-of-queue word.
- rd_almost_empty, out, 1, rd_count <= AE_LEVEL.
- rd_count, out, ADDR_W+1, occupancy seen from clk_2, including the output register.

Behaviour:
- Reset, write domain:
  - rst is sampled on clk_1.
  - While high, the write pointers clear, wr_count = 0, wr_overflow = 0, wr_almost_full = 0, and wr_full = 1 (blocks writes).
  - wr_full falls on the first clk_1 edge after rst deasserts.
- Reset, read domain:
  - rst passes through a SYNC_STAGES synchroniser into clk_2 as rst_2.
  - While rst_2 is high: rd_valid = 0, rd_data = 0, rd_count = 0, rd_almost_empty = 1, and the read pointers clear.
  - rst must be held for at least SYNC_STAGES+2 clk_2 periods. Shorter pulses are illegal and the bench flags them.
- Pointers:
  - Binary and Gray pointers, ADDR_W+1 bits each. The MSB distinguishes full from empty on wrap-around.
  - The RAM is addressed by the low ADDR_W bits.
- Write:
  - A word is accepted at a clk_1 edge when wr_en=1 and wr_full=0. The word is stored and the pointer increments.
  - If wr_en=1 and wr_full=1, the write is dropped, storage is unchanged, and wr_overflow sets. wr_overflow stays set until rst.
- Full:
  - wr_full = 1 when next write Gray pointer == synchronised read Gray pointer with the top two bits inverted. It is registered.
  - This is conservative: a read in clk_2 frees space only SYNC_STAGES+1 clk_1 edges later.
- Empty:
  - The RAM is empty when the read Gray pointer == synchronised write Gray pointer.
- Output register (FWFT):
  - When rd_valid=0, or when rd_valid=1 and rd_ready=1, and the RAM is non-empty, the head word loads into rd_data with rd_valid=1 at that clk_2 edge.
  - If the RAM is empty at that moment, rd_valid goes to 0 and rd_data holds its last value.
  - rd_ready is ignored while rd_valid=0.
- Latency:
  - Write at clk_1 edge to rd_valid high takes SYNC_STAGES+1 clk_2 edges, +1 for phase uncertainty.
  - Back-to-back reads sustain one word per clk_2 cycle.
- Counts:
  - wr_count = wr_bin - gray2bin(synchronised rd_ptr), modulo 2^(ADDR_W+1). It never underestimates occupancy.
  - rd_count = synchronised wr_bin - rd_bin + rd_valid. It never overestimates occupancy.
  - Flags are registered from the counts of the same cycle.
- Simultaneous events:
  - A write while full is rejected even if a read is occurring in clk_2.
  - A read and a write of the last word in the same period is legal. rd_valid may drop for up to SYNC_STAGES+1 cycles.
- Clock ratio: any ratio, with no assumption on relative frequency.

Decomposition:
- Package fifo_pkg: bin2gray and gray2bin functions, and a DEPTH constant derived from ADDR_W.
- Sub-module sync_ff (parameters WIDTH, STAGES): a plain flop chain.
  - One instance each for rd_gray into clk_1, wr_gray into clk_2, and rst into clk_2.
- RAM inferred inline: written on clk_1, read on clk_2.

Test Plan:
- Reset: rst high for 6 clk_2 cycles with clk_1=100MHz and clk_2=37MHz.
  - Expect wr_full=1, wr_count=0, rd_valid=0, rd_almost_empty=1.
  - After release, wr_full=0 on the next clk_1 edge.
- Fill: write 8 words 0x0001..0x0008 with rd_ready=0.
  - wr_full=1 after the 8th write, wr_almost_full=1 from count 6.
  - A 9th write (0xDEAD) sets wr_overflow and is dropped.
- Drain: rd_ready=1 after the fill.
  - rd_data shows 0x0001..0x0008 in order, one per clk_2 cycle, with no 0xDEAD.
  - rd_valid falls after 0x0008.
  - wr_full clears within SYNC_STAGES+2 clk_1 edges of the first read.
- Wrap-around: 40 words of an incrementing pattern with random wr_en/rd_ready at 50% duty, swapping to clk_1=37MHz and clk_2=100MHz.
  - Output order matches the scoreboard across five pointer wraps.
  - wr_count >= true occupancy and rd_count <= true occupancy every cycle.
- Single word: one write of 0xA5A5 into an empty FIFO.
  - rd_valid=1 with rd_data=0xA5A5 within SYNC_STAGES+2 clk_2 edges.
  - With rd_ready=0 held 10 cycles, the word stays stable.
- Mid-operation reset: rst asserted with 5 words stored and a read in progress.
  - Both sides return to reset values.
  - The next written word 0x1234 is the first rd_data after release; no stale data appears.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray-code conversion and depth derivation.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 3;
    localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Plain flop chain that carries a signal into another clock domain.
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk_i) begin
        chain_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) begin
            chain_q[i] <= chain_q[i-1];
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/async_fifo_fwft.sv
// Dual-clock FIFO with Gray-coded pointer crossing and a first-word-fall-through
// output register, plus occupancy counts, level flags and a sticky overflow flag.
module async_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = FIFO_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 6,
    parameter int AE_LEVEL    = 1
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              clk_2,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_almost_full,
    output logic [ADDR_W:0]   wr_count,
    output logic              wr_overflow,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_almost_empty,
    output logic [ADDR_W:0]   rd_count
);

    localparam int             PTR_W  = ADDR_W + 1;
    localparam int             DEPTH  = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] AF_THR = PTR_W'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR = PTR_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
    logic [PTR_W-1:0] wr_count_q, wr_count_d, rd_gray_w, rd_bin_w;
    logic             wr_full_q, wr_full_d, wr_af_q, wr_ovf_q, wr_accept;

    logic [PTR_W-1:0]  rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
    logic [PTR_W-1:0]  rd_count_q, rd_count_d, wr_gray_r, wr_bin_r;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d, rd_ae_q, ram_empty, rst_2;

    sync_ff #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rd_gray_sync (
        .clk_i(clk_1), .d_i(rd_gray_q), .q_o(rd_gray_w)
    );
    sync_ff #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wr_gray_sync (
        .clk_i(clk_2), .d_i(wr_gray_q), .q_o(wr_gray_r)
    );
    sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rst_sync (
        .clk_i(clk_2), .d_i(rst), .q_o(rst_2)
    );

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        wr_accept  = wr_en && !wr_full_q && !rst;
        wr_bin_d   = wr_bin_q + PTR_W'(wr_accept);
        wr_gray_d  = PTR_W'(bin2gray(32'(wr_bin_d)));
        rd_bin_w   = PTR_W'(gray2bin(32'(rd_gray_w)));
        wr_count_d = wr_bin_d - rd_bin_w;
        // Full when the write side is exactly one lap ahead of the synchronised read side.
        wr_full_d  = (wr_gray_d == {~rd_gray_w[PTR_W-1 -: 2], rd_gray_w[PTR_W-3:0]});
    end

    // NOTE: clocked state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            wr_bin_q   <= '0;
            wr_gray_q  <= '0;
            wr_count_q <= '0;
            wr_full_q  <= 1'b1;
            wr_af_q    <= 1'b0;
            wr_ovf_q   <= 1'b0;
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_gray_q  <= wr_gray_d;
            wr_count_q <= wr_count_d;
            wr_full_q  <= wr_full_d;
            wr_af_q    <= (wr_count_d >= AF_THR);
            if (wr_en && wr_full_q) begin
                wr_ovf_q <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; cleared pointers make stale contents unreachable.
    always_ff @(posedge clk_1) begin
        if (wr_accept) begin
            mem[wr_bin_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        ram_empty  = (rd_gray_q == wr_gray_r);
        wr_bin_r   = PTR_W'(gray2bin(32'(wr_gray_r)));
        rd_bin_d   = rd_bin_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        // The output register refills whenever it is empty or being consumed.
        if (!rd_valid_q || rd_ready) begin
            if (!ram_empty) begin
                rd_bin_d   = rd_bin_q + PTR_W'(1);
                rd_valid_d = 1'b1;
                rd_data_d  = mem[rd_bin_q[ADDR_W-1:0]];
            end else begin
                rd_valid_d = 1'b0;
            end
        end
        rd_gray_d  = PTR_W'(bin2gray(32'(rd_bin_d)));
        rd_count_d = wr_bin_r - rd_bin_d + PTR_W'(rd_valid_d);
    end

    always_ff @(posedge clk_2) begin
        if (rst_2) begin
            rd_bin_q   <= '0;
            rd_gray_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_count_q <= '0;
            rd_ae_q    <= 1'b1;
        end else begin
            rd_bin_q   <= rd_bin_d;
            rd_gray_q  <= rd_gray_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_count_q <= rd_count_d;
            rd_ae_q    <= (rd_count_d <= AE_THR);
        end
    end

    assign wr_full         = wr_full_q;
    assign wr_almost_full  = wr_af_q;
    assign wr_count        = wr_count_q;
    assign wr_overflow     = wr_ovf_q;
    assign rd_valid        = rd_valid_q;
    assign rd_data         = rd_data_q;
    assign rd_almost_empty = rd_ae_q;
    assign rd_count        = rd_count_q;

endmodule
